// File: rtl/mux_bus_ctrl.sv
// Demultiplexing bus controller: latches address from a multiplexed AD bus on ALE,
// runs read/write accesses with programmable wait states and decoded chip selects.
module mux_bus_ctrl #(
  parameter int   ADDR_W = 16,
  parameter int   DATA_W = 8,
  parameter int   N_CS   = 4,
  parameter int   WAIT_W = 4,
  parameter logic IOM    = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ALE,
  input  logic                     io_m,
  input  logic                     rdb,
  input  logic                     wrb,
  input  logic [DATA_W-1:0]        AD_in,
  input  logic [ADDR_W-DATA_W-1:0] A_hi,
  input  logic [WAIT_W-1:0]        wait_cfg,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     OEb,
  output logic                     WR_RDb,
  output logic [N_CS-1:0]          csb,
  output logic [ADDR_W-1:0]        addr_lat,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     wr_stb,
  output logic [DATA_W-1:0]        AD_out,
  output logic                     AD_oe,
  output logic                     READY,
  output logic                     abort
);

  localparam int CS_W = $clog2(N_CS);

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    ADDR     = 7'b0000010,
    RD_WAIT  = 7'b0000100,
    WR_WAIT  = 7'b0001000,
    RD_DONE  = 7'b0010000,
    WR_DONE  = 7'b0100000,
    TRISTATE = 7'b1000000
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              iom_r;
  logic [WAIT_W-1:0] cnt_r;
  logic              abort_nx_s;
  logic              sel_s;
  logic [N_CS-1:0]   csb_nx_s;

  // Next-state decode; a released strobe during a wait state wins over the count.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (ALE) state_nx_s = ADDR;
        else     state_nx_s = IDLE;
      end
      ADDR: begin
        if (iom_r != IOM) state_nx_s = IDLE;
        else if (ALE)     state_nx_s = ADDR;
        else if (!wrb)    state_nx_s = WR_WAIT;
        else if (!rdb)    state_nx_s = RD_WAIT;
        else              state_nx_s = ADDR;
      end
      RD_WAIT: begin
        if (rdb)                          state_nx_s = TRISTATE;
        else if (cnt_r == {WAIT_W{1'b0}}) state_nx_s = RD_DONE;
        else                              state_nx_s = RD_WAIT;
      end
      WR_WAIT: begin
        if (wrb)                          state_nx_s = TRISTATE;
        else if (cnt_r == {WAIT_W{1'b0}}) state_nx_s = WR_DONE;
        else                              state_nx_s = WR_WAIT;
      end
      RD_DONE: begin
        if (rdb) state_nx_s = TRISTATE;
        else     state_nx_s = RD_DONE;
      end
      WR_DONE: begin
        if (wrb) state_nx_s = TRISTATE;
        else     state_nx_s = WR_DONE;
      end
      TRISTATE: state_nx_s = IDLE;
      default:  state_nx_s = IDLE;
    endcase
  end

  // Abort flag and chip-select pattern for the upcoming state.
  always_comb begin
    abort_nx_s = ((state_r == RD_WAIT) && rdb) || ((state_r == WR_WAIT) && wrb);
    sel_s      = state_nx_s inside {RD_WAIT, WR_WAIT, RD_DONE, WR_DONE};
    csb_nx_s   = {N_CS{1'b1}};
    for (int i = 0; i < N_CS; i++) begin
      if (sel_s && (addr_lat[ADDR_W-1 -: CS_W] == CS_W'(i))) csb_nx_s[i] = 1'b0;
      else                                                   csb_nx_s[i] = 1'b1;
    end
  end

  // State, datapath registers and outputs registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      iom_r    <= 1'b0;
      cnt_r    <= {WAIT_W{1'b0}};
      addr_lat <= {ADDR_W{1'b0}};
      wr_data  <= {DATA_W{1'b0}};
      AD_out   <= {DATA_W{1'b0}};
      OEb      <= 1'b1;
      WR_RDb   <= 1'b0;
      csb      <= {N_CS{1'b1}};
      wr_stb   <= 1'b0;
      AD_oe    <= 1'b0;
      READY    <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s == ADDR && ALE) begin
        addr_lat <= {A_hi, AD_in};
        iom_r    <= io_m;
      end
      if (state_r == ADDR && state_nx_s == WR_WAIT) begin
        wr_data <= AD_in;
      end
      // wait_cfg is only looked at when leaving ADDR.
      if (state_r == ADDR && (state_nx_s inside {RD_WAIT, WR_WAIT})) begin
        cnt_r <= wait_cfg;
      end else if ((state_r inside {RD_WAIT, WR_WAIT}) && cnt_r != {WAIT_W{1'b0}}) begin
        cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
      end
      if (state_r == RD_WAIT && state_nx_s == RD_DONE) begin
        AD_out <= rd_data;
      end
      OEb    <= !(state_nx_s inside {RD_WAIT, RD_DONE});
      WR_RDb <= state_nx_s inside {WR_WAIT, WR_DONE};
      READY  <= state_nx_s inside {RD_DONE, WR_DONE};
      AD_oe  <= (state_nx_s == RD_DONE);
      wr_stb <= (state_r == WR_WAIT) && (state_nx_s == WR_DONE);
      abort  <= abort_nx_s;
      csb    <= csb_nx_s;
    end
  end

endmodule
